// File: rtl/mdu_ex.sv
// Iterative multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// The pipeline is frozen through stall from issue until the result is ready.
//
// Handshake: start is a level request held by EX. It is accepted only in IDLE.
// stall stays high from the accepting cycle through the last RUN cycle. In the
// single DONE cycle, done=1 and stall=0, so the pipeline advances on that edge
// while start is ignored. result_hi/lo are valid from DONE until the next
// operation completes.
module mdu_ex #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic               is_div;
    logic               neg_lo;     // negate product / quotient
    logic               neg_hi;     // negate remainder (dividend sign)
    logic               div_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;        // holds dividend bits, quotient shifts in at LSB
    logic [CW-1:0]      count;

    // Operand conditioning: signed ops work on magnitudes.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    assign a_neg = ~op[0] & operand_a[WIDTH-1];
    assign b_neg = ~op[0] & operand_b[WIDTH-1];
    assign a_abs = a_neg ? (~operand_a + 1'b1) : operand_a;
    assign b_abs = b_neg ? (~operand_b + 1'b1) : operand_b;

    // One iteration of each datapath, plus the final sign fixup.
    logic [2*WIDTH-1:0] acc_nxt, prod_fix;
    logic [WIDTH+1:0]   div_wide, div_diff;
    logic [WIDTH:0]     rem_nxt;
    logic [WIDTH-1:0]   quo_nxt, quo_fix, rem_fix;

    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
    assign div_wide = {rem, quo[WIDTH-1]};
    assign div_diff = div_wide - {2'b00, divisor};
    assign rem_nxt  = div_diff[WIDTH+1] ? div_wide[WIDTH:0] : div_diff[WIDTH:0];
    assign quo_nxt  = {quo[WIDTH-2:0], ~div_diff[WIDTH+1]};
    assign prod_fix = neg_lo ? (~acc_nxt + 1'b1) : acc_nxt;
    assign quo_fix  = neg_lo ? (~quo_nxt + 1'b1) : quo_nxt;
    assign rem_fix  = neg_hi ? (~rem_nxt[WIDTH-1:0] + 1'b1) : rem_nxt[WIDTH-1:0];

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                stall = start;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                stall = 1'b1;
                if (count == LAST) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    // Datapath: latch operands on issue, iterate in RUN, register results on the last step.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div_zero  <= 1'b0;
            a_raw     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            divisor   <= '0;
            rem       <= '0;
            quo       <= '0;
            count     <= '0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= a_neg;
                        div_zero <= op[1] & (operand_b == '0);
                        a_raw    <= operand_a;
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, a_abs};
                        mplier   <= b_abs;
                        divisor  <= b_abs;
                        rem      <= '0;
                        quo      <= a_abs;
                        count    <= '0;
                    end
                end
                S_RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    rem    <= rem_nxt;
                    quo    <= quo_nxt;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        if (!is_div) begin
                            result_hi <= prod_fix[2*WIDTH-1:WIDTH];
                            result_lo <= prod_fix[WIDTH-1:0];
                        end else if (div_zero) begin
                            result_hi <= a_raw;
                            result_lo <= '1;
                        end else begin
                            result_hi <= rem_fix;
                            result_lo <= quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ex.sv
// Directed bench for mdu_ex: latency, stall/busy shape, arithmetic corners,
// mid-operation reset and back-to-back issue.
module tb_mdu_ex;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        stall, busy, done;
    logic [31:0] result_hi, result_lo;
    logic [1:0]  dbg_state;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_hi = '0, last_lo = '0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mdu_ex #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .stall(stall), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .dbg_state(dbg_state)
    );

    // Clock and reset.
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op (start left high) and follow it to its done pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int done_cyc, stall_bad, busy_bad;
        logic [63:0] e;
        @(posedge clock); #1;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        exp_q.push_back({eh, el});
        done_cyc = -1; stall_bad = 0; busy_bad = 0;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            @(negedge clock);
            if (done) begin
                done_cyc = cyc;
                check({tag, "_stall_at_done"}, {31'd0, stall}, 32'd0);
                check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
                e = exp_q.pop_front();
                check({tag, "_hi"}, result_hi, e[63:32]);
                check({tag, "_lo"}, result_lo, e[31:0]);
                last_hi = e[63:32]; last_lo = e[31:0];
                break;
            end
            if (stall !== 1'b1) stall_bad++;
            if (busy !== (cyc != 0)) busy_bad++;
        end
        if (done_cyc < 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'd33);
        check({tag, "_stall_shape"}, 32'(stall_bad), 32'd0);
        check({tag, "_busy_shape"}, 32'(busy_bad), 32'd0);
    endtask

    // Drop start and confirm the unit is quiet and results hold.
    task automatic idle(input string tag);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_stall"}, {31'd0, stall}, 32'd0);
        check({tag, "_hold_hi"}, result_hi, last_hi);
        check({tag, "_hold_lo"}, result_lo, last_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", result_hi, 32'd0);
        check("rst_lo", result_lo, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);

        run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001); idle("a");
        run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB); idle("b");
        run_op("mult_min", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000); idle("c");
        run_op("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD); idle("d");
        run_op("div_negb", DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD); idle("e");
        run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000); idle("f");
        run_op("divu_zero", DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF); idle("g");
        run_op("div_zero", DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF); idle("h");
        run_op("divu_big", DIVU, 32'hFFFFFFFF, 32'd16, 32'h0000000F, 32'h0FFFFFFF); idle("i");

        // Reset during RUN cycle 10 aborts with no done pulse and clears results.
        @(posedge clock); #1;
        start = 1'b1; op = MULTU; operand_a = 32'd1234; operand_b = 32'd5678;
        repeat (11) @(negedge clock);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b1; start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", result_hi, 32'd0);
        check("abort_lo", result_lo, 32'd0);
        last_hi = '0; last_lo = '0;
        repeat (30) @(negedge clock);
        check("abort_no_done", {31'd0, done}, 32'd0);

        // Back-to-back: start stays high through DONE into a fresh op.
        run_op("b2b_mul", MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
        run_op("b2b_div", DIVU, 32'd42, 32'd5, 32'd2, 32'd8);
        idle("j");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
